// File: rtl/grom_io_pkg.sv
// ---------------------------------------------------------------------------
// grom_io_pkg: shared register offsets and constants for grom8 I/O devices.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package grom_io_pkg;

  localparam logic [1:0] BTN_REG_LEVEL = 2'd0;
  localparam logic [1:0] BTN_REG_EVENT = 2'd1;
  localparam logic [1:0] BTN_REG_ID    = 2'd2;

  localparam logic [7:0] BTN_ID_BASE   = 8'hB0;

  // 10 ms at 25 MHz
  localparam int unsigned BTN_DEBOUNCE_DEFAULT = 250000;

  function automatic logic [7:0] btn_id(input int unsigned n_btn);
    return BTN_ID_BASE | 8'(n_btn);
  endfunction

endpackage

`default_nettype wire

// File: rtl/grom_button_port_if.sv
// ---------------------------------------------------------------------------
// grom_button_port_if: grom8 I/O bus slice seen by the button port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface grom_button_port_if;
  logic       sel;
  logic [1:0] addr;
  logic       ioreq;
  logic       we;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  modport master (output sel, addr, ioreq, we, data_in, input data_out, irq);
  modport slave  (input sel, addr, ioreq, we, data_in, output data_out, irq);
endinterface

`default_nettype wire

// File: rtl/grom_debounce.sv
// ---------------------------------------------------------------------------
// grom_debounce: 2-flop synchroniser plus counter debouncer for one button.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module grom_debounce
  import grom_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count only while the synchronised input disagrees; any agreement restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  // Strobe coincides with the edge that updates level, so events land with it.
  assign rise_o  = level_d & ~level_q;

endmodule

`default_nettype wire

// File: rtl/grom_button_port.sv
// ---------------------------------------------------------------------------
// grom_button_port: debounced push-button read port on the grom8 I/O bus.
// Optional registered irq output when GROM_BTN_IRQ_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module grom_button_port
  import grom_io_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BTN-1:0]     i_Switch,
  grom_button_port_if.slave    bus
);

  localparam logic [7:0] ID_VALUE = btn_id(N_BTN);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] event_q, event_d;
  logic [N_BTN-1:0] clr_mask;
  logic [7:0]       rd_data;
  logic [7:0]       data_out_q;
  logic             rd;
  logic             wr;
  logic             unused_data_hi;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    grom_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (i_Switch[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );
  end

  assign rd = bus.ioreq & bus.sel & ~bus.we;
  assign wr = bus.ioreq & bus.sel &  bus.we;

  // Only the low N_BTN write bits address event flags.
  assign unused_data_hi = ^bus.data_in;

  always_comb begin
    clr_mask = '0;
    if (bus.addr == BTN_REG_EVENT) begin
      if (rd) begin
        clr_mask = event_q;
      end else if (wr) begin
        clr_mask = bus.data_in[N_BTN-1:0];
      end
    end
  end

  // A new press in the clearing cycle survives and is reported next read.
  assign event_d = (event_q & ~clr_mask) | rise;

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      BTN_REG_LEVEL: rd_data[N_BTN-1:0] = level;
      BTN_REG_EVENT: rd_data[N_BTN-1:0] = event_q;
      BTN_REG_ID:    rd_data            = ID_VALUE;
      default:       rd_data            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q    <= '0;
      data_out_q <= '0;
    end else begin
      event_q <= event_d;
      if (rd) begin
        data_out_q <= rd_data;
      end
    end
  end

  assign bus.data_out = data_out_q;

`ifdef GROM_BTN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |event_q;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

`default_nettype wire
